// File: rtl/eth_pkg.sv
// Shared Ethernet constants: RMII framing dibits, CRC-32 parameters, receive FSM encoding.
// Also holds the byte-wide reflected CRC-32 step used by the receive and transmit paths.
package eth_pkg;

    localparam logic [1:0]  ETH_PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0]  ETH_SFD_DIBIT      = 2'b11;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_PREAMBLE = 2'd1;
    localparam logic [1:0]  ST_DATA     = 2'd2;
    localparam logic [1:0]  ST_DROP     = 2'd3;

    // One byte through the LSB-first CRC-32; the result is not complemented.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide reflected CRC-32 register (uncomplemented). Init loads the seed, En folds in Data.
// Shared with eth_packet_former for FCS generation.
module eth_crc32
    import eth_pkg::*;
(
    input  logic        Clk,
    input  logic        Rstn,
    input  logic        Init,
    input  logic        En,
    input  logic [7:0]  Data,
    output logic [31:0] Crc
);

    logic [31:0] crc_reg;

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            crc_reg <= 32'd0;
        end else if (Init) begin
            crc_reg <= CRC32_INIT;
        end else if (En) begin
            crc_reg <= crc32_byte(crc_reg, Data);
        end
    end

    assign Crc = crc_reg;

endmodule

// File: rtl/eth_rmii_rx.sv
// RMII receive path: strips preamble/SFD, assembles bytes, checks length and FCS, and
// emits each frame as an AXI-Stream byte stream with the bad-frame verdict on tlast.
module eth_rmii_rx
    import eth_pkg::*;
#(
    parameter int MIN_FRAME    = 64,
    parameter int MAX_FRAME    = 1518,
    parameter int PREAMBLE_MIN = 8
) (
    input  logic        Clk,
    input  logic        Rstn,
    input  logic [1:0]  Rx_Data,
    input  logic        Crs_Dv,
    input  logic        Rx_Er,
    output logic [7:0]  AXIS_Master_tdata,
    output logic        AXIS_Master_tvalid,
    output logic        AXIS_Master_tlast,
    output logic        AXIS_Master_tuser,
    output logic [15:0] Frame_Cnt,
    output logic [15:0] Err_Cnt
);

    localparam int               LEN_W   = $clog2(MAX_FRAME + 2);
    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME);
    localparam logic [3:0]       PRE_MIN = 4'(PREAMBLE_MIN);

    logic [1:0]       rx_data_reg;
    logic             crs_dv_reg, rx_er_reg;
    logic [1:0]       state_reg, state_next;
    logic [3:0]       pre_cnt_reg, pre_cnt_next;
    logic [1:0]       phase_reg, phase_next;
    logic [5:0]       shift_reg, shift_next;
    logic [7:0]       hold_reg, hold_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic             er_seen_reg, er_seen_next;
    logic [7:0]       tdata_next;
    logic             tvalid_next, tlast_next, tuser_next;
    logic [15:0]      frame_cnt_next, err_cnt_next;
    logic             crc_init, crc_en, frame_bad;
    logic [7:0]       byte_done;
    logic [31:0]      crc_val;

    assign byte_done = {rx_data_reg, shift_reg};
    assign frame_bad = er_seen_reg || rx_er_reg || (phase_reg != 2'd0) ||
                       (len_reg < MIN_LEN) || (crc_val != CRC32_RESIDUE);

    eth_crc32 u_crc (
        .Clk  (Clk),
        .Rstn (Rstn),
        .Init (crc_init),
        .En   (crc_en),
        .Data (byte_done),
        .Crc  (crc_val)
    );

    always_comb begin
        state_next     = state_reg;
        pre_cnt_next   = pre_cnt_reg;
        phase_next     = phase_reg;
        shift_next     = shift_reg;
        hold_next      = hold_reg;
        len_next       = len_reg;
        er_seen_next   = er_seen_reg;
        tdata_next     = AXIS_Master_tdata;
        tvalid_next    = 1'b0;
        tlast_next     = 1'b0;
        tuser_next     = 1'b0;
        frame_cnt_next = Frame_Cnt;
        err_cnt_next   = Err_Cnt;
        crc_init       = 1'b0;
        crc_en         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (crs_dv_reg) begin
                    state_next   = ST_PREAMBLE;
                    pre_cnt_next = 4'd0;
                end
            end
            ST_PREAMBLE: begin
                if (!crs_dv_reg) begin
                    state_next = ST_IDLE;
                end else begin
                    case (rx_data_reg)
                        ETH_PREAMBLE_DIBIT: if (pre_cnt_reg != 4'hF) pre_cnt_next = pre_cnt_reg + 4'd1;
                        ETH_SFD_DIBIT: begin
                            if (pre_cnt_reg >= PRE_MIN) begin
                                state_next   = ST_DATA;
                                phase_next   = 2'd0;
                                len_next     = '0;
                                er_seen_next = 1'b0;
                                crc_init     = 1'b1;
                            end else begin
                                state_next = ST_DROP;
                            end
                        end
                        2'b10:   state_next = ST_DROP;
                        default: ;
                    endcase
                end
            end
            ST_DATA: begin
                if (!crs_dv_reg) begin
                    // Carrier gone: the held byte is the true last byte of the frame.
                    state_next = ST_IDLE;
                    if (len_reg != '0) begin
                        tdata_next  = hold_reg;
                        tvalid_next = 1'b1;
                        tlast_next  = 1'b1;
                        tuser_next  = frame_bad;
                        if (frame_bad) err_cnt_next   = Err_Cnt + 16'd1;
                        else           frame_cnt_next = Frame_Cnt + 16'd1;
                    end else begin
                        err_cnt_next = Err_Cnt + 16'd1;
                    end
                end else begin
                    er_seen_next = er_seen_reg | rx_er_reg;
                    shift_next   = byte_done[7:2];
                    phase_next   = phase_reg + 2'd1;
                    if (phase_reg == 2'd3) begin
                        if (len_reg == MAX_LEN) begin
                            tdata_next   = hold_reg;
                            tvalid_next  = 1'b1;
                            tlast_next   = 1'b1;
                            tuser_next   = 1'b1;
                            err_cnt_next = Err_Cnt + 16'd1;
                            state_next   = ST_DROP;
                        end else begin
                            crc_en    = 1'b1;
                            len_next  = len_reg + 1'b1;
                            hold_next = byte_done;
                            if (len_reg != '0) begin
                                tdata_next  = hold_reg;
                                tvalid_next = 1'b1;
                            end
                        end
                    end
                end
            end
            default: begin
                if (!crs_dv_reg) state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            rx_data_reg        <= 2'd0;
            crs_dv_reg         <= 1'b0;
            rx_er_reg          <= 1'b0;
            state_reg          <= ST_IDLE;
            pre_cnt_reg        <= 4'd0;
            phase_reg          <= 2'd0;
            shift_reg          <= 6'd0;
            hold_reg           <= 8'd0;
            len_reg            <= '0;
            er_seen_reg        <= 1'b0;
            AXIS_Master_tdata  <= 8'd0;
            AXIS_Master_tvalid <= 1'b0;
            AXIS_Master_tlast  <= 1'b0;
            AXIS_Master_tuser  <= 1'b0;
            Frame_Cnt          <= 16'd0;
            Err_Cnt            <= 16'd0;
        end else begin
            rx_data_reg        <= Rx_Data;
            crs_dv_reg         <= Crs_Dv;
            rx_er_reg          <= Rx_Er;
            state_reg          <= state_next;
            pre_cnt_reg        <= pre_cnt_next;
            phase_reg          <= phase_next;
            shift_reg          <= shift_next;
            hold_reg           <= hold_next;
            len_reg            <= len_next;
            er_seen_reg        <= er_seen_next;
            AXIS_Master_tdata  <= tdata_next;
            AXIS_Master_tvalid <= tvalid_next;
            AXIS_Master_tlast  <= tlast_next;
            AXIS_Master_tuser  <= tuser_next;
            Frame_Cnt          <= frame_cnt_next;
            Err_Cnt            <= err_cnt_next;
        end
    end

endmodule

// File: tb/tb_eth_rmii_rx.sv
// Self-checking bench for eth_rmii_rx: directed and random frames against a frame-level model.
module tb_eth_rmii_rx;

    localparam int MIN_FRAME = 64;
    localparam int MAX_FRAME = 1518;
    localparam int PRE_MIN   = 8;

    logic        Clk = 1'b0;
    logic        Rstn = 1'b0;
    logic [1:0]  Rx_Data = 2'b00;
    logic        Crs_Dv = 1'b0;
    logic        Rx_Er = 1'b0;
    logic [7:0]  AXIS_Master_tdata;
    logic        AXIS_Master_tvalid, AXIS_Master_tlast, AXIS_Master_tuser;
    logic [15:0] Frame_Cnt, Err_Cnt;

    eth_rmii_rx dut (
        .Clk                (Clk),
        .Rstn               (Rstn),
        .Rx_Data            (Rx_Data),
        .Crs_Dv             (Crs_Dv),
        .Rx_Er              (Rx_Er),
        .AXIS_Master_tdata  (AXIS_Master_tdata),
        .AXIS_Master_tvalid (AXIS_Master_tvalid),
        .AXIS_Master_tlast  (AXIS_Master_tlast),
        .AXIS_Master_tuser  (AXIS_Master_tuser),
        .Frame_Cnt          (Frame_Cnt),
        .Err_Cnt            (Err_Cnt)
    );

    always #10 Clk = ~Clk;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] frame_q[$];
    logic [9:0] obs_q[$];
    logic [9:0] exp_q[$];
    int         exp_frames = 0;
    int         exp_errs = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (AXIS_Master_tvalid)
            obs_q.push_back({AXIS_Master_tuser, AXIS_Master_tlast, AXIS_Master_tdata});
    end

    // Ethernet FCS (complemented reflected CRC-32) over the first n bytes of frame_q.
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'd0, frame_q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bit fcs_ok(input int n);
        if (n < 4) return 1'b0;
        return fcs_of(n - 4) == {frame_q[n-1], frame_q[n-2], frame_q[n-3], frame_q[n-4]};
    endfunction

    task automatic build_frame(input int n_payload, input bit rnd);
        logic [31:0] fcs;
        frame_q.delete();
        for (int i = 0; i < n_payload; i++) frame_q.push_back(rnd ? 8'($urandom) : 8'(i));
        fcs = fcs_of(n_payload);
        for (int k = 0; k < 4; k++) frame_q.push_back(fcs[8*k +: 8]);
    endtask

    // Expected stream for one carrier: pre_dibits 01s then SFD then dd data dibits.
    task automatic model(input int pre_dibits, input int dd, input bit rx_er);
        int n = dd / 4;
        bit bad;
        // The first carrier dibit is consumed by the idle-to-preamble transition.
        if (pre_dibits - 1 < PRE_MIN) return;
        if (n > MAX_FRAME) begin
            for (int i = 0; i < MAX_FRAME; i++)
                exp_q.push_back({(i == MAX_FRAME - 1) ? 2'b11 : 2'b00, frame_q[i]});
            exp_errs++;
            return;
        end
        if (n == 0) begin
            exp_errs++;
            return;
        end
        bad = rx_er || (dd % 4 != 0) || (n < MIN_FRAME) || !fcs_ok(n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == n - 1) ? {bad, 1'b1} : 2'b00, frame_q[i]});
        if (bad) exp_errs++;
        else     exp_frames++;
    endtask

    task automatic drive(input int pre_dibits, input int dd, input int er_dibit,
                         input int rst_dibit, input int ipg);
        logic [7:0] b;
        for (int i = 0; i < pre_dibits; i++) begin
            @(negedge Clk);
            Crs_Dv = 1'b1;
            Rx_Data = 2'b01;
        end
        @(negedge Clk);
        Crs_Dv = 1'b1;
        Rx_Data = 2'b11;
        for (int d = 0; d < dd; d++) begin
            @(negedge Clk);
            b = frame_q[d / 4];
            Rx_Data = b[2*(d % 4) +: 2];
            Rx_Er = (d == er_dibit);
            if (d == rst_dibit) begin
                Rstn = 1'b0;
                #1;
                check("rst tvalid", AXIS_Master_tvalid, 0);
                check("rst tlast", AXIS_Master_tlast, 0);
                check("rst tdata", AXIS_Master_tdata, 0);
                check("rst frame_cnt", Frame_Cnt, 0);
                check("rst err_cnt", Err_Cnt, 0);
                obs_q.delete();
            end else begin
                Rstn = 1'b1;
            end
        end
        @(negedge Clk);
        Crs_Dv = 1'b0;
        Rx_Data = 2'b00;
        Rx_Er = 1'b0;
        Rstn = 1'b1;
        repeat (ipg - 1) @(negedge Clk);
    endtask

    task automatic run_check(input string tag);
        int n;
        int f0;
        repeat (4) @(negedge Clk);
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        check({tag, " byte count"}, obs_q.size(), exp_q.size());
        f0 = n_fail;
        for (int i = 0; i < n && n_fail == f0; i++)
            check({tag, " byte"}, obs_q[i], exp_q[i]);
        check({tag, " frame_cnt"}, Frame_Cnt, exp_frames);
        check({tag, " err_cnt"}, Err_Cnt, exp_errs);
        $display("%s: %0d bytes out, Frame_Cnt=%0d Err_Cnt=%0d", tag, obs_q.size(), Frame_Cnt, Err_Cnt);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int len, kind, dd;
        #5;
        check("reset tvalid", AXIS_Master_tvalid, 0);
        check("reset tlast", AXIS_Master_tlast, 0);
        check("reset tuser", AXIS_Master_tuser, 0);
        check("reset tdata", AXIS_Master_tdata, 0);
        check("reset frame_cnt", Frame_Cnt, 0);
        check("reset err_cnt", Err_Cnt, 0);
        repeat (2) @(negedge Clk);
        Rstn = 1'b1;
        repeat (2) @(negedge Clk);

        build_frame(60, 1'b0);
        model(31, 256, 1'b0); drive(31, 256, -1, -1, 2); run_check("good64");

        frame_q[10] = frame_q[10] ^ 8'h04;
        model(31, 256, 1'b0); drive(31, 256, -1, -1, 2); run_check("bitflip");

        build_frame(60, 1'b1);
        model(31, 256, 1'b1); drive(31, 256, 20 * 4 + 1, -1, 2); run_check("rx_er");

        model(31, 255, 1'b0); drive(31, 255, -1, -1, 2); run_check("partial");

        model(3, 256, 1'b0); drive(3, 256, -1, -1, 2); run_check("short_pre");

        build_frame(1596, 1'b1);
        model(31, 6400, 1'b0); drive(31, 6400, -1, -1, 2); run_check("oversize");

        build_frame(60, 1'b1);
        model(31, 256, 1'b0); drive(31, 256, -1, -1, 2);
        build_frame(60, 1'b1);
        model(31, 256, 1'b0); drive(31, 256, -1, -1, 2); run_check("back2back");

        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(64, 160);
            kind = $urandom_range(0, 4);
            build_frame(len - 4, 1'b1);
            dd = len * 4;
            case (kind)
                1: begin
                    int k = $urandom_range(0, len - 1);
                    frame_q[k] = frame_q[k] ^ (8'd1 << $urandom_range(0, 7));
                end
                2: begin
                    len = $urandom_range(5, 63);
                    build_frame(len - 4, 1'b1);
                    dd = len * 4;
                end
                3: dd = len * 4 - $urandom_range(1, 3);
                4: dd = $urandom_range(0, 7);
                default: ;
            endcase
            model(31, dd, 1'b0); drive(31, dd, -1, -1, 2);
            run_check($sformatf("random%0d kind%0d len%0d", it, kind, dd / 4));
        end

        frame_q.delete();
        for (int i = 0; i < 64; i++) frame_q.push_back(8'hAA);
        exp_frames = 0;
        exp_errs = 0;
        drive(31, 256, -1, 30 * 4, 2); run_check("reset_mid");

        build_frame(60, 1'b1);
        model(31, 256, 1'b0); drive(31, 256, -1, -1, 2); run_check("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
